store_buffer: RTL

Write-side companion to the data memory load path. Accepts SB/SH/SW requests from the pipeline MEM stage, aligns data onto byte lanes, and generates 4-bit write strobes. Queues stores in a small FIFO and drains them one per cycle into the memory write port. Flags loads that hit a pending store word so the hazard unit can stall.

---
 rtl/dm_pkg.sv | 20 ++
 rtl/store_align.sv | 47 ++++
 rtl/store_buffer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory write side: funct3 encodings,
// strobe width and the layout of one queued store.
package dm_pkg;

    localparam int STRB_W    = 4;
    localparam int SB_ADDR_W = 9;   // byte-address width of the entry layout
    localparam int SB_DATA_W = 32;  // data width of the entry layout

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    // One pending store, already word-aligned and lane-steered.
    typedef struct packed {
        logic [SB_ADDR_W-1:0] waddr;
        logic [SB_DATA_W-1:0] wdata;
        logic [STRB_W-1:0]    wstrb;
    } sb_entry_t;

endpackage

// File: rtl/store_align.sv
// Steers SB/SH/SW data onto byte lanes and builds the write strobe.
// "misaligned" also covers unsupported funct3 codes: either way the
// store is dropped by the buffer.
module store_align
    import dm_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        addr,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              misaligned
);

    // Lane replication and strobe generation per access size.
    always_comb begin
        wdata      = '0;
        wstrb      = '0;
        misaligned = 1'b0;
        case (funct3)
            F3_SB: begin
                wstrb = 4'(4'b0001 << addr);
                wdata = {4{data[7:0]}};
            end
            F3_SH: begin
                if (addr[0]) begin
                    misaligned = 1'b1;
                end else begin
                    wstrb = 4'(4'b0011 << addr);
                    wdata = {2{data[15:0]}};
                end
            end
            F3_SW: begin
                if (addr != 2'b00) begin
                    misaligned = 1'b1;
                end else begin
                    wstrb = 4'b1111;
                    wdata = data;
                end
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Small in-order store queue between the MEM stage and the data memory
// write port. Drains one entry per cycle and flags loads that touch a
// word with a pending store. The entry layout follows dm_pkg widths, so
// DM_ADDRESS/DATA_W are expected to stay at their package defaults.
module store_buffer
    import dm_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [DM_ADDRESS-1:0] st_addr,
    input  logic [DATA_W-1:0]     st_data,
    input  logic [2:0]            st_funct3,
    output logic                  mem_wr_en,
    input  logic                  mem_ready,
    output logic [DM_ADDRESS-1:0] mem_waddr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [STRB_W-1:0]     mem_wstrb,
    input  logic                  ld_check,
    input  logic [DM_ADDRESS-1:0] ld_addr,
    output logic                  ld_hazard,
    output logic                  misaligned_err,
    output logic                  empty,
    output logic                  full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    sb_entry_t            entry_mem [DEPTH];
    logic [DEPTH-1:0]     vld_reg;
    logic [PTR_W-1:0]     head_reg;
    logic [PTR_W-1:0]     tail_reg;
    logic [CNT_W-1:0]     count_reg;
    logic                 misaligned_err_reg;

    logic [DATA_W-1:0]    align_wdata;
    logic [STRB_W-1:0]    align_wstrb;
    logic                 align_reject;
    logic                 accept;
    logic                 push;
    logic                 pop;
    sb_entry_t            new_entry;
    sb_entry_t            head_entry;
    logic [DEPTH-1:0]     entry_hit;
    logic                 incoming_hit;
    logic                 unused_ld_low;

    store_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .addr       (st_addr[1:0]),
        .funct3     (st_funct3),
        .data       (st_data),
        .wdata      (align_wdata),
        .wstrb      (align_wstrb),
        .misaligned (align_reject)
    );

    assign full      = (count_reg == CNT_W'(DEPTH));
    assign empty     = (count_reg == '0);
    assign st_ready  = !full;
    assign mem_wr_en = !empty;

    // A rejected store is still consumed; only good ones take a slot.
    assign accept = st_valid && st_ready;
    assign push   = accept && !align_reject;
    assign pop    = mem_wr_en && mem_ready;

    assign new_entry.waddr = {st_addr[DM_ADDRESS-1:2], 2'b00};
    assign new_entry.wdata = align_wdata;
    assign new_entry.wstrb = align_wstrb;

    // Write port is driven straight from the head register slot.
    assign head_entry = entry_mem[head_reg];
    assign mem_waddr  = head_entry.waddr;
    assign mem_wdata  = head_entry.wdata;
    assign mem_wstrb  = head_entry.wstrb;

    // Per-slot word match against the load; popping entries still count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign entry_hit[gi] = vld_reg[gi]
                && (entry_mem[gi].waddr[DM_ADDRESS-1:2] == ld_addr[DM_ADDRESS-1:2])
                && (entry_mem[gi].wstrb != '0);
        end
    endgenerate

    assign incoming_hit = push
        && (st_addr[DM_ADDRESS-1:2] == ld_addr[DM_ADDRESS-1:2])
        && (align_wstrb != '0);

    assign ld_hazard = ld_check && ((|entry_hit) || incoming_hit);

    // Byte offset of the load is irrelevant to a word-granular hazard.
    assign unused_ld_low = &{1'b0, ld_addr[1:0]};

    // Queue payload; no reset needed since vld_reg/count gate every use.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_mem[tail_reg] <= new_entry;
        end
    end

    // Pointers, occupancy, slot valids and the reject pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg           <= '0;
            tail_reg           <= '0;
            count_reg          <= '0;
            vld_reg            <= '0;
            misaligned_err_reg <= 1'b0;
        end else begin
            misaligned_err_reg <= accept && align_reject;
            if (pop) begin
                vld_reg[head_reg] <= 1'b0;
                head_reg          <= head_reg + PTR_W'(1);
            end
            if (push) begin
                vld_reg[tail_reg] <= 1'b1;
                tail_reg          <= tail_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    assign misaligned_err = misaligned_err_reg;

endmodule
